// File: rtl/precision_mode_ctrl.sv
// Precision mode controller for the fused bit-brick array.
// Takes input/weight precision configs over a valid/ready handshake and holds
// them in a shadow register. Once all in-flight MAC ops have drained, it
// commits them atomically and drives per-brick signed masks to the array.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   cfg_valid/cfg_ready   config handshake (accept when both high)
//   cfg_in_width          one-hot requested input precision (bit k = 2^k bits)
//   cfg_wt_width          one-hot requested weight precision
//   op_issue/op_retire    one op entered/left the array this cycle
//   issue_allow           array may issue new ops
//   in_width/wt_width     committed precisions
//   in_signed             per-brick signed flags, input operand
//   weight_signed         per-brick signed flags, weight operand
//   cfg_applied           1-cycle pulse when a new config goes live
//   err                   sticky [0] illegal width, [1] overflow, [2] underflow
//   err_clr               clears err; a new error in the same cycle wins
module precision_mode_ctrl #(
    parameter int unsigned NUM_BRICKS   = 4,
    parameter int unsigned WW           = 4,
    parameter int unsigned MAX_INFLIGHT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WW-1:0]         cfg_in_width,
    input  logic [WW-1:0]         cfg_wt_width,
    input  logic                  op_issue,
    input  logic                  op_retire,
    output logic                  issue_allow,
    output logic [WW-1:0]         in_width,
    output logic [WW-1:0]         wt_width,
    output logic [NUM_BRICKS-1:0] in_signed,
    output logic [NUM_BRICKS-1:0] weight_signed,
    output logic                  cfg_applied,
    output logic [2:0]            err,
    input  logic                  err_clr
);

    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [WW-1:0]         MAXW_OH  = {1'b1, {(WW-1){1'b0}}};
    localparam logic [NUM_BRICKS-1:0] MSB_MASK = {1'b1, {(NUM_BRICKS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WW-1:0]           shadow_in_q, shadow_in_d;
    logic [WW-1:0]           shadow_wt_q, shadow_wt_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    cfg_ready_d, issue_allow_d, cfg_applied_d;
    logic [WW-1:0]           in_width_d, wt_width_d;
    logic [NUM_BRICKS-1:0]   in_signed_d, weight_signed_d;
    logic [2:0]              new_err, err_d;
    logic                    cfg_legal;

    function automatic logic is_onehot(input logic [WW-1:0] w);
        return (w != '0) && ((w & (w - WW'(1))) == '0);
    endfunction

    // Bricks per operand is max(w/2,1); the top brick of each operand group is signed.
    function automatic logic [NUM_BRICKS-1:0] sign_mask(input logic [WW-1:0] w);
        logic [NUM_BRICKS-1:0] m;
        int bpo;
        bpo = 1;
        for (int k = 1; k < int'(WW); k++) begin
            if (w[k]) bpo = 1 << (k - 1);
        end
        for (int i = 0; i < int'(NUM_BRICKS); i++) begin
            m[i] = ((i % bpo) == (bpo - 1));
        end
        return m;
    endfunction

    assign cfg_legal = is_onehot(cfg_in_width) && is_onehot(cfg_wt_width);

    // Next state, counter, errors, and next values of the registered outputs.
    always_comb begin
        state_d         = state_q;
        shadow_in_d     = shadow_in_q;
        shadow_wt_d     = shadow_wt_q;
        cnt_d           = cnt_q;
        new_err         = 3'b000;
        cfg_ready_d     = 1'b0;
        issue_allow_d   = 1'b0;
        cfg_applied_d   = 1'b0;
        in_width_d      = in_width;
        wt_width_d      = wt_width;
        in_signed_d     = in_signed;
        weight_signed_d = weight_signed;

        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    if (cfg_legal) begin
                        shadow_in_d = cfg_in_width;
                        shadow_wt_d = cfg_wt_width;
                        state_d     = PENDING;
                    end else begin
                        new_err[0] = 1'b1;
                    end
                end
            end
            PENDING: begin
                if ((cnt_q == '0) && !op_issue) state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the state being entered.
        case (state_d)
            IDLE: begin
                cfg_ready_d   = 1'b1;
                issue_allow_d = 1'b1;
            end
            COMMIT: begin
                cfg_applied_d   = 1'b1;
                in_width_d      = shadow_in_q;
                wt_width_d      = shadow_wt_q;
                in_signed_d     = sign_mask(shadow_in_q);
                weight_signed_d = sign_mask(shadow_wt_q);
            end
            default: ;
        endcase

        // Issues are counted even while issue_allow is low.
        case ({op_issue, op_retire})
            2'b10: begin
                if (cnt_q == CW'(MAX_INFLIGHT)) new_err[1] = 1'b1;
                else                            cnt_d = cnt_q + CW'(1);
            end
            2'b01: begin
                if (cnt_q == '0) new_err[2] = 1'b1;
                else             cnt_d = cnt_q - CW'(1);
            end
            default: ;
        endcase

        err_d = (err & ~{3{err_clr}}) | new_err;
    end

    // State, shadow, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            shadow_in_q   <= MAXW_OH;
            shadow_wt_q   <= MAXW_OH;
            cnt_q         <= '0;
            cfg_ready     <= 1'b1;
            issue_allow   <= 1'b1;
            cfg_applied   <= 1'b0;
            in_width      <= MAXW_OH;
            wt_width      <= MAXW_OH;
            in_signed     <= MSB_MASK;
            weight_signed <= MSB_MASK;
            err           <= 3'b000;
        end else begin
            state_q       <= state_d;
            shadow_in_q   <= shadow_in_d;
            shadow_wt_q   <= shadow_wt_d;
            cnt_q         <= cnt_d;
            cfg_ready     <= cfg_ready_d;
            issue_allow   <= issue_allow_d;
            cfg_applied   <= cfg_applied_d;
            in_width      <= in_width_d;
            wt_width      <= wt_width_d;
            in_signed     <= in_signed_d;
            weight_signed <= weight_signed_d;
            err           <= err_d;
        end
    end

endmodule

// File: tb/tb_precision_mode_ctrl.sv
// Directed bench for precision_mode_ctrl: default 4-brick instance plus an
// 8-brick instance for the wider mask patterns.
module tb_precision_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid, cfg_ready;
    logic [3:0] cfg_in_width, cfg_wt_width;
    logic       op_issue, op_retire, issue_allow;
    logic [3:0] in_width, wt_width, in_signed, weight_signed;
    logic       cfg_applied;
    logic [2:0] err;
    logic       err_clr;

    logic       cfg8_valid, cfg8_ready;
    logic [4:0] cfg8_in_width, cfg8_wt_width;
    logic       op8_issue, op8_retire, issue8_allow;
    logic [4:0] in8_width, wt8_width;
    logic [7:0] in8_signed, weight8_signed;
    logic       cfg8_applied;
    logic [2:0] err8;
    logic       err8_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    precision_mode_ctrl u_dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_in_width(cfg_in_width), .cfg_wt_width(cfg_wt_width),
        .op_issue(op_issue), .op_retire(op_retire), .issue_allow(issue_allow),
        .in_width(in_width), .wt_width(wt_width),
        .in_signed(in_signed), .weight_signed(weight_signed),
        .cfg_applied(cfg_applied), .err(err), .err_clr(err_clr)
    );

    precision_mode_ctrl #(.NUM_BRICKS(8), .WW(5), .MAX_INFLIGHT(15)) u_dut8 (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg8_valid), .cfg_ready(cfg8_ready),
        .cfg_in_width(cfg8_in_width), .cfg_wt_width(cfg8_wt_width),
        .op_issue(op8_issue), .op_retire(op8_retire), .issue_allow(issue8_allow),
        .in_width(in8_width), .wt_width(wt8_width),
        .in_signed(in8_signed), .weight_signed(weight8_signed),
        .cfg_applied(cfg8_applied), .err(err8), .err_clr(err8_clr)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks every status output of the 4-brick instance.
    task automatic check_all(input string tag, input logic rdy, input logic allow,
                             input logic [3:0] iw, input logic [3:0] ww,
                             input logic [3:0] im, input logic [3:0] wm,
                             input logic ap, input logic [2:0] e);
        check({tag, ".cfg_ready"},     32'(cfg_ready),     32'(rdy));
        check({tag, ".issue_allow"},   32'(issue_allow),   32'(allow));
        check({tag, ".in_width"},      32'(in_width),      32'(iw));
        check({tag, ".wt_width"},      32'(wt_width),      32'(ww));
        check({tag, ".in_signed"},     32'(in_signed),     32'(im));
        check({tag, ".weight_signed"}, 32'(weight_signed), 32'(wm));
        check({tag, ".cfg_applied"},   32'(cfg_applied),   32'(ap));
        check({tag, ".err"},           32'(err),           32'(e));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        cfg_valid = 0; cfg_in_width = '0; cfg_wt_width = '0;
        op_issue = 0; op_retire = 0; err_clr = 0;
        cfg8_valid = 0; cfg8_in_width = '0; cfg8_wt_width = '0;
        op8_issue = 0; op8_retire = 0; err8_clr = 0;

        // 1: reset values, then a config with the array idle
        do_reset();
        check_all("rst", 1, 1, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 0, 3'b000);
        cfg_valid = 1; cfg_in_width = 4'b0001; cfg_wt_width = 4'b0100;
        tick();
        cfg_valid = 0;
        check_all("t1.pend", 0, 0, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 0, 3'b000);
        tick();
        check_all("t1.commit", 0, 0, 4'b0001, 4'b0100, 4'b1111, 4'b1010, 1, 3'b000);
        tick();
        check_all("t1.idle", 1, 1, 4'b0001, 4'b0100, 4'b1111, 4'b1010, 0, 3'b000);

        // 2: commit waits for three in-flight ops to retire
        do_reset();
        op_issue = 1;
        tick(3);
        op_issue = 0;
        cfg_valid = 1; cfg_in_width = 4'b0100; cfg_wt_width = 4'b1000;
        tick();
        cfg_valid = 0;
        tick(2);
        check_all("t2.wait", 0, 0, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 0, 3'b000);
        op_retire = 1;
        tick(2);
        check("t2.retire2.in_signed", 32'(in_signed), 32'h8);
        tick();
        op_retire = 0;
        check("t2.retire3.applied", 32'(cfg_applied), 32'h0);
        check("t2.retire3.in_signed", 32'(in_signed), 32'h8);
        tick();
        check_all("t2.commit", 0, 0, 4'b0100, 4'b1000, 4'b1010, 4'b1000, 1, 3'b000);
        tick();
        check("t2.idle.cfg_ready", 32'(cfg_ready), 32'h1);

        // 3: illegal (non one-hot) width is rejected and flagged
        cfg_valid = 1; cfg_in_width = 4'b0110; cfg_wt_width = 4'b1000;
        tick();
        cfg_valid = 0;
        check_all("t3.bad", 1, 1, 4'b0100, 4'b1000, 4'b1010, 4'b1000, 0, 3'b001);
        tick(2);
        check("t3.sticky", 32'(err), 32'h1);
        check("t3.no_commit", 32'(cfg_applied), 32'h0);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("t3.clr", 32'(err), 32'h0);

        // 4: saturation at MAX_INFLIGHT and underflow at zero
        op_issue = 1;
        tick(15);
        check("t4.at15.err", 32'(err), 32'h0);
        tick();
        op_issue = 0;
        check("t4.ovf.err", 32'(err), 32'h2);
        op_retire = 1;
        tick(15);
        check("t4.at0.err", 32'(err), 32'h2);
        tick();
        check("t4.unf.err", 32'(err), 32'h6);
        err_clr = 1;
        tick();
        check("t4.clr_vs_new.err", 32'(err), 32'h4);
        op_retire = 0;
        tick();
        err_clr = 0;
        check("t4.clr.err", 32'(err), 32'h0);

        // 5: balanced issue+retire keeps PENDING waiting; reset aborts it
        op_issue = 1;
        tick(2);
        op_issue = 0;
        cfg_valid = 1; cfg_in_width = 4'b0010; cfg_wt_width = 4'b0010;
        tick();
        cfg_valid = 0;
        op_issue = 1; op_retire = 1;
        tick(3);
        op_issue = 0; op_retire = 0;
        check_all("t5.hold", 0, 0, 4'b0100, 4'b1000, 4'b1010, 4'b1000, 0, 3'b000);
        tick(2);
        check("t5.still_pend.applied", 32'(cfg_applied), 32'h0);
        check("t5.still_pend.ready", 32'(cfg_ready), 32'h0);
        reset = 1'b1;
        tick();
        check_all("t5.in_rst", 1, 1, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 0, 3'b000);
        reset = 1'b0;
        tick(3);
        check_all("t5.after_rst", 1, 1, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 0, 3'b000);

        // 2-bit width gives all-signed bricks
        cfg_valid = 1; cfg_in_width = 4'b0010; cfg_wt_width = 4'b1000;
        tick();
        cfg_valid = 0;
        tick();
        check_all("t5.w2", 0, 0, 4'b0010, 4'b1000, 4'b1111, 4'b1000, 1, 3'b000);

        // 6: 8-brick instance
        check("t6.rst.in_signed", 32'(in8_signed), 32'h80);
        check("t6.rst.ready", 32'(cfg8_ready), 32'h1);
        check("t6.rst.err", 32'(err8), 32'h0);
        cfg8_valid = 1; cfg8_in_width = 5'b10000; cfg8_wt_width = 5'b00100;
        tick();
        cfg8_valid = 0;
        check("t6.pend.allow", 32'(issue8_allow), 32'h0);
        tick();
        check("t6.commit.applied", 32'(cfg8_applied), 32'h1);
        check("t6.commit.in_signed", 32'(in8_signed), 32'h80);
        check("t6.commit.weight_signed", 32'(weight8_signed), 32'hAA);
        check("t6.commit.in_width", 32'(in8_width), 32'h10);
        check("t6.commit.wt_width", 32'(wt8_width), 32'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
